// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: reset/trap vectors,
// FSM state encoding and small address helpers.
package fetch_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'hBFC0_0380;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Instructions are word aligned; any set low bit makes a target illegal.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Next-PC selection for the fetch controller.
// Priority: trap > branch/jump redirect > sequential advance > hold.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
  input  logic        trap_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        advance,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        redirect,
  output logic        misalign
);

  always_comb begin
    pc_next  = pc;
    misalign = 1'b0;
    redirect = trap_valid | redirect_valid;
    if (trap_valid) begin
      pc_next = TRAP_VEC;
    end else if (redirect_valid) begin
      // An unaligned target is turned into a trap rather than fetched.
      if (is_misaligned(redirect_target)) begin
        pc_next  = TRAP_VEC;
        misalign = 1'b1;
      end else begin
        pc_next = redirect_target;
      end
    end else if (advance) begin
      pc_next = pc + INSTR_BYTES;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding request FSM, PC register,
// redirect/kill handling and the instruction output register toward decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         kill_q, kill_d;
  logic         misalign_q, misalign_d;

  logic granted;
  logic redirect;
  logic sel_misalign;

  assign granted = (state_q == ST_REQ) && imem_gnt;

  pc_next_sel #(
    .TRAP_VEC(TRAP_VEC)
  ) u_pc_next_sel (
    .trap_valid      (trap_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .advance         (granted),
    .pc              (pc_q),
    .pc_next         (pc_d),
    .redirect        (redirect),
    .misalign        (sel_misalign)
  );

  always_comb begin
    // NOTE: every variable gets its default before the case, so no path
    // through this block leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q && stall;
    misalign_d    = sel_misalign;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (imem_gnt) begin
          fetch_pc_d = pc_q;
          kill_d     = redirect;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          // A redirect landing with the response kills it just like an
          // earlier one would have.
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
            state_d       = stall ? ST_HOLD : ST_REQ;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect || !stall) state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase

    if (redirect) instr_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VEC;
      fetch_pc_q    <= '0;
      kill_q        <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      kill_q        <= kill_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory/redirect driver predicts PCs and
// delivered instructions; a monitor compares each accepted instruction.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
  localparam logic [31:0] TRAP_VEC  = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trap_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trap_valid      (trap_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .misalign        (misalign)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  int total = 0;
  int bad   = 0;

  exp_t        sb[$];
  logic [31:0] gq[$];
  logic [31:0] acc_pcs[$];
  int          acc_cnt = 0;

  // Reference model state.
  logic [31:0] m_pc = RESET_VEC;
  bit          outst = 0;
  int          cnt = 0;
  logic [31:0] o_addr = '0;
  bit          o_kill = 0;
  int          hold_cnt = 0;
  bit          exp_mis = 0;

  // Stimulus knobs and one-shot overrides.
  int          p_gnt = 100, p_redir = 0, p_trap = 0, p_spur = 0, p_stall = 0;
  int          lat_min = 1, lat_max = 1;
  bit          f_trap = 0, f_redir = 0, f_spur = 0;
  logic [31:0] f_target = '0;
  int          f_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'hBFC0_0000 | {20'd0, 10'($urandom_range(1023)), 2'b00};
    if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | {28'd0, 2'($urandom_range(3)), 2'b00};
    if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3, 1));
    return t;
  endfunction

  // One clock cycle: drive inputs at the falling edge and predict the effect
  // of the following rising edge.
  task automatic step();
    bit          resp, do_r, do_t, gnt, mis, was_outst, kill_now, spur;
    logic [31:0] tgt;
    @(negedge clk);
    check1("misalign", misalign, exp_mis);
    resp = 0;
    if (outst) begin
      cnt--;
      resp = (cnt == 0);
    end
    do_r = 0;
    do_t = 0;
    if (hold_cnt == 0) begin
      do_t = f_trap || (int'($urandom_range(99)) < p_trap);
      do_r = f_redir || (int'($urandom_range(99)) < p_redir);
    end
    tgt = f_redir ? f_target : rand_target();
    f_trap = 0;
    f_redir = 0;
    gnt = int'($urandom_range(99)) < p_gnt;
    spur = !outst && (f_spur || int'($urandom_range(99)) < p_spur);
    f_spur = 0;
    kill_now = resp && (o_kill || do_r || do_t);
    if (hold_cnt > 0) begin
      stall = 1'b1;
      hold_cnt--;
    end else if (resp && !kill_now && (f_stall > 0 || int'($urandom_range(99)) < p_stall)) begin
      stall = 1'b1;
      hold_cnt = (f_stall > 0) ? f_stall : int'($urandom_range(4, 1));
      f_stall = 0;
    end else begin
      stall = 1'b0;
    end
    imem_gnt        = gnt;
    trap_valid      = do_t;
    redirect_valid  = do_r;
    redirect_target = tgt;
    imem_rvalid     = resp || spur;
    imem_rdata      = resp ? mem_word(o_addr) : $urandom();

    was_outst = outst;
    if (resp) begin
      if (!kill_now) sb.push_back({mem_word(o_addr), o_addr});
      outst = 0;
    end else if (outst && (do_r || do_t)) begin
      o_kill = 1;
    end
    if (imem_req && gnt) begin
      check("req_addr", imem_addr, m_pc);
      check1("single_outstanding", was_outst, 1'b0);
      gq.push_back(imem_addr);
      outst  = 1;
      cnt    = int'($urandom_range(lat_max, lat_min));
      o_addr = imem_addr;
      o_kill = do_r || do_t;
    end
    mis = do_r && !do_t && (tgt[1:0] != 2'b00);
    if (do_t || mis) m_pc = TRAP_VEC;
    else if (do_r) m_pc = tgt;
    else if (imem_req && gnt) m_pc = m_pc + 32'd4;
    exp_mis = mis;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check1("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, RESET_VEC);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check1("rst_misalign", misalign, 1'b0);
    trap_valid = 0; redirect_valid = 0; stall = 0; imem_gnt = 0; imem_rvalid = 0;
    sb.delete(); gq.delete(); acc_pcs.delete();
    m_pc = RESET_VEC; outst = 0; o_kill = 0; hold_cnt = 0; exp_mis = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step_until_grant(input string name, input int budget);
    int n;
    n = gq.size();
    for (int i = 0; i < budget && gq.size() == n; i++) step();
    check1(name, gq.size() > n, 1'b1);
  endtask

  // Monitor: pops an expectation for every accepted instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && instr_valid && !stall) begin
        acc_cnt++;
        acc_pcs.push_back(instr_pc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_instr: got pc %h, expected none", instr_pc);
        end else begin
          e = sb.pop_front();
          check("instr", instr, e.word);
          check("instr_pc", instr_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0, n08, n_held;
    bit          ok;
    logic [31:0] rec, rec_pc;

    // Reset release, continuous grant/rvalid: sequential fetch.
    do_reset();
    step(); check1("idle_no_req", imem_req, 1'b0);
    step(); check1("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RESET_VEC);
    repeat (4) step();
    a0 = acc_cnt;
    repeat (20) step();
    check("throughput_20cyc", 32'(acc_cnt - a0), 32'd10);
    check1("seq_have3", gq.size() >= 3 && acc_pcs.size() >= 3, 1'b1);
    if (gq.size() >= 3 && acc_pcs.size() >= 3) begin
      check("seq_addr0", gq[0], 32'hBFC0_0000);
      check("seq_addr1", gq[1], 32'hBFC0_0004);
      check("seq_addr2", gq[2], 32'hBFC0_0008);
      check("seq_pc2", acc_pcs[2], 32'hBFC0_0008);
    end

    // Redirect while waiting on 0xBFC00008.
    do_reset();
    lat_min = 2; lat_max = 2;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (gq.size() > 0 && gq[$] == 32'hBFC0_0008) ok = 1;
    end
    check1("reach_08", ok, 1'b1);
    f_redir = 1; f_target = 32'hBFC0_0100;
    step();
    step_until_grant("grant_after_redir", 10);
    check("redir_addr", gq[$], 32'hBFC0_0100);
    repeat (6) step();
    n08 = 0;
    foreach (acc_pcs[i]) if (acc_pcs[i] == 32'hBFC0_0008) n08++;
    check("killed_08_count", 32'(n08), 32'd0);

    // Five-cycle stall on a presented instruction.
    lat_min = 1; lat_max = 1;
    f_stall = 5;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (instr_valid && stall) ok = 1;
    end
    check1("stall_seen", ok, 1'b1);
    rec = instr; rec_pc = instr_pc;
    n_held = 0;
    while (stall && n_held < 12) begin
      check("hold_instr", instr, rec);
      check("hold_pc", instr_pc, rec_pc);
      check1("hold_valid", instr_valid, 1'b1);
      check1("hold_no_req", imem_req, 1'b0);
      n_held++;
      step();
    end
    check("hold_cycles", 32'(n_held), 32'd5);
    step_until_grant("grant_after_hold", 10);
    check("after_hold_addr", gq[$], rec_pc + 32'd4);

    // Trap wins over a simultaneous branch.
    f_trap = 1; f_redir = 1; f_target = 32'hBFC0_0200;
    step(); step();
    check("trap_priority", imem_addr, TRAP_VEC);
    repeat (4) step();

    // Misaligned branch target.
    f_redir = 1; f_target = 32'hBFC0_0102;
    step(); step();
    check1("misalign_pulse", misalign, 1'b1);
    check("misalign_addr", imem_addr, TRAP_VEC);
    step();
    check1("misalign_drop", misalign, 1'b0);

    // PC wrap at the top of the address space.
    f_redir = 1; f_target = 32'hFFFF_FFFC;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (gq.size() > 0 && gq[$] == 32'hFFFF_FFFC) ok = 1;
    end
    check1("reach_fffffffc", ok, 1'b1);
    step_until_grant("grant_after_wrap", 10);
    check("wrap_addr", gq[$], 32'h0000_0000);

    // Reset while a request is outstanding, late rvalid in IDLE.
    lat_min = 3; lat_max = 3;
    step_until_grant("grant_before_rst", 10);
    step();
    do_reset();
    f_spur = 1;
    step(); check1("late_rvalid_idle", imem_req, 1'b0);
    step(); check1("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, RESET_VEC);
    repeat (8) step();

    // Randomised traffic with a reset in the middle.
    p_gnt = 70; p_redir = 8; p_trap = 3; p_spur = 20; p_stall = 30;
    lat_min = 1; lat_max = 3;
    repeat (1500) step();
    do_reset();
    repeat (1500) step();
    p_gnt = 0; p_redir = 0; p_trap = 0; p_spur = 0;
    repeat (14) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
